// File: rtl/aes_round_seq.sv
// AES-128 decryption round sequencer: orders the datapath steps
// (AddRoundKey, InvShiftRows, InvSubBytes, InvMixColumns per column)
// for one decryption after the key schedule has settled.
//
// Ports:
//   CLK, RESET (sync, active-high)
//   AES_START  level request; AES_DONE held until it drops
//   BUSY       high in all states except WAIT and DONE
//   OP_SEL     0 none, 1 ARK, 2 ISR, 3 ISB, 4 IMC
//   STATE_LD   load datapath result into state register
//   SRC_MSG    ARK input from AES_MSG_ENC instead of state
//   RK_IDX     round-key index 0..10
//   COL_SEL    InvMixColumns column
//   ROUND      inner-loop round 1..9, else 0
//   OUT_LD     latch final ARK result into AES_MSG_DEC
//   ABORT      only with `define AES_SEQ_ABORT_EN
module aes_round_seq #(
  parameter int KEYEXP_CYCLES = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
`ifdef AES_SEQ_ABORT_EN
  input  logic       ABORT,
`endif
  output logic       AES_DONE,
  output logic       BUSY,
  output logic [2:0] OP_SEL,
  output logic       STATE_LD,
  output logic       SRC_MSG,
  output logic [3:0] RK_IDX,
  output logic [1:0] COL_SEL,
  output logic [3:0] ROUND,
  output logic       OUT_LD
);

  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_KEYEXP = 4'd1,
    S_INIT   = 4'd2,
    S_L_ISR  = 4'd3,
    S_L_ISB  = 4'd4,
    S_L_ARK  = 4'd5,
    S_L_IMC  = 4'd6,
    S_F_ISR  = 4'd7,
    S_F_ISB  = 4'd8,
    S_F_ARK  = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ARK  = 3'd1;
  localparam logic [2:0] OP_ISR  = 3'd2;
  localparam logic [2:0] OP_ISB  = 3'd3;
  localparam logic [2:0] OP_IMC  = 3'd4;

  localparam logic [3:0] KX_LOAD = 4'(KEYEXP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] round_q, round_d;
  logic [1:0] col_q, col_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_WAIT;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  assign ROUND = round_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    col_d    = 2'd0;
    AES_DONE = 1'b0;
    BUSY     = 1'b0;
    OP_SEL   = OP_NONE;
    STATE_LD = 1'b0;
    SRC_MSG  = 1'b0;
    RK_IDX   = 4'd0;
    COL_SEL  = 2'd0;
    OUT_LD   = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (AES_START) begin
          state_d = S_KEYEXP;
          cnt_d   = KX_LOAD;
        end
      end
      S_KEYEXP: begin
        BUSY = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_INIT: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ARK;
        SRC_MSG  = 1'b1;
        RK_IDX   = 4'd10;
        STATE_LD = 1'b1;
        round_d  = 4'd1;
        state_d  = S_L_ISR;
      end
      S_L_ISR: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ISR;
        STATE_LD = 1'b1;
        state_d  = S_L_ISB;
      end
      S_L_ISB: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ISB;
        STATE_LD = 1'b1;
        state_d  = S_L_ARK;
      end
      S_L_ARK: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ARK;
        RK_IDX   = 4'd10 - round_q;
        STATE_LD = 1'b1;
        state_d  = S_L_IMC;
      end
      S_L_IMC: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_IMC;
        COL_SEL  = col_q;
        STATE_LD = 1'b1;
        if (col_q == 2'd3) begin
          if (round_q == 4'd9) begin
            round_d = 4'd0;
            state_d = S_F_ISR;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_L_ISR;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_F_ISR: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ISR;
        STATE_LD = 1'b1;
        state_d  = S_F_ISB;
      end
      S_F_ISB: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ISB;
        STATE_LD = 1'b1;
        state_d  = S_F_ARK;
      end
      S_F_ARK: begin
        BUSY     = 1'b1;
        OP_SEL   = OP_ARK;
        STATE_LD = 1'b1;
        OUT_LD   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        AES_DONE = 1'b1;
        if (!AES_START) begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = 4'd0;
        round_d = 4'd0;
      end
    endcase
`ifdef AES_SEQ_ABORT_EN
    if (ABORT && (state_q != S_WAIT)) begin
      state_d = S_WAIT;
      cnt_d   = 4'd0;
      round_d = 4'd0;
      col_d   = 2'd0;
    end
`endif
  end

endmodule
